// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - two-port framebuffer arbiter (display line fetch vs. host) onto a single-port RAM
module fb_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 24,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk_25MHz,
  input  logic              rst,
  // display read port
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  // host read/write port
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  // single-port RAM
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Consecutive cycles the host has been kept waiting; saturates at STARVE_LIM.
  logic [CNT_W-1:0] starve_cnt;
  logic             host_force;
  // One-cycle read-return tracking: a read is in flight and who owns it.
  logic             rd_pend;
  logic             rd_owner_host;

  // Grant decision and RAM command mux: display wins unless the host is starved.
  always_comb begin
    host_force = host_req && (starve_cnt == STARVE_LIM);
    host_gnt   = !rst && host_req && (host_force || !disp_req);
    disp_gnt   = !rst && disp_req && !host_force;
    mem_en     = host_gnt || disp_gnt;
    mem_we     = host_gnt && host_we;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (disp_gnt) begin
      mem_addr  = disp_addr;
    end
  end

  // Starvation counter: clears whenever the host is served or stops asking.
  // A forced host grant clears it, so the display automatically wins next cycle.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!host_req || host_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Owner tag for the read issued this cycle; RAM data returns next cycle.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      rd_pend       <= 1'b0;
      rd_owner_host <= 1'b0;
    end else begin
      rd_pend       <= disp_gnt || (host_gnt && !host_we);
      rd_owner_host <= host_gnt;
    end
  end

  // Return path: rvalid is masked during reset so a read issued just before
  // reset asserts never shows up.
  always_comb begin
    disp_rvalid = !rst && rd_pend && !rd_owner_host;
    host_rvalid = !rst && rd_pend && rd_owner_host;
    disp_rdata  = mem_rdata;
    host_rdata  = mem_rdata;
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 11, framebuffer word address width; DATA_W, default 24, pixel word width (RGB888); STARVE_MAX, default 16, maximum consecutive cycles a host request may wait.
REQ-002 Port clk_25MHz  in  1  is the single system clock; all logic SHALL be on its rising edge.
REQ-003 Port rst  in  1  is the reset: synchronous, active-high.
REQ-004 Port disp_req  in  1  is the display line-fetch read request.
REQ-005 Port disp_addr  in  ADDR_W  is the display read address.
REQ-006 Port disp_gnt  out  1  means the display request is accepted this cycle.
REQ-007 Port disp_rvalid  out  1  means disp_rdata is valid.
REQ-008 Port disp_rdata  out  DATA_W  is the display read data.
REQ-009 Port host_req  in  1  is the host access request.
REQ-010 Port host_we  in  1  selects host write (1) or read (0).
REQ-011 Port host_addr  in  ADDR_W  is the host address.
REQ-012 Port host_wdata  in  DATA_W  is the host write data.
REQ-013 Port host_gnt  out  1  means the host request is accepted this cycle.
REQ-014 Port host_rvalid  out  1  means host_rdata is valid (reads only).
REQ-015 Port host_rdata  out  DATA_W  is the host read data.
REQ-016 Port mem_en  out  1  is the single-port RAM enable.
REQ-017 Port mem_we  out  1  is the RAM write enable.
REQ-018 Port mem_addr  out  ADDR_W  is the RAM address.
REQ-019 Port mem_wdata  out  DATA_W  is the RAM write data.
REQ-020 Port mem_rdata  in  DATA_W  is RAM read data, valid exactly one cycle after a read enable.

Function
REQ-021 Grants SHALL be combinational from the current-cycle requests and registered arbiter state; at most one of disp_gnt, host_gnt is high per cycle.
REQ-022 Granted access SHALL drive mem_en=1, mem_addr, mem_we (host_we for host, 0 for display) and mem_wdata in the same cycle; with no grant, mem_en=0 and mem_we=0.
REQ-023 Requesters SHALL hold req/addr/we/wdata stable until their grant; a request without a grant is not consumed.
REQ-024 Priority: display wins by default; host wins only when the starvation counter equals STARVE_MAX.
REQ-025 Starvation counter: resets to 0 on host grant or when host_req=0; increments by 1 per cycle host_req=1 without a grant; saturates at STARVE_MAX.
REQ-026 When the counter forces a host grant while disp_req=1, the display SHALL be granted on the next cycle if still requesting, so the display never loses more than one cycle per STARVE_MAX+1 cycles.
REQ-027 For each granted read, a one-bit owner tag SHALL be registered; exactly one cycle after the grant, the owner's rvalid is 1 for one cycle, and its rdata equals mem_rdata.
REQ-028 Host writes SHALL NOT produce host_rvalid.
REQ-029 disp_rdata/host_rdata SHALL be driven from mem_rdata and are meaningful only while the matching rvalid is 1.
REQ-030 Back-to-back grants every cycle SHALL be supported; throughput is one access per cycle.
REQ-031 Simultaneous read and write to the same address in consecutive cycles SHALL return RAM order: a read granted after a write returns the new data.

Reset
REQ-032 While rst=1: all grants, mem_en, mem_we, and both rvalid outputs SHALL be 0; the starvation counter and owner tag SHALL be cleared.
REQ-033 A read granted in the cycle before rst asserts SHALL have its rvalid suppressed.
REQ-034 The first grant SHALL be possible in the first cycle with rst=0.

Verification
REQ-035 Display only, disp_req held for 4 cycles at addresses 0..3 -> disp_gnt=1 for 4 cycles, disp_rvalid one cycle later, with data matching preloaded words.
REQ-036 Host write 0xABCDEF at address 5, then host read of address 5 -> host_gnt on both; host_rvalid=1 once with host_rdata=0xABCDEF; no disp_rvalid.
REQ-037 disp_req and host_req held continuously, STARVE_MAX=16 -> host granted on the 17th cycle, display granted on the next; pattern repeats every 17 cycles.
REQ-038 host_req dropped after 10 waiting cycles and reasserted -> counter restarts at 0; no forced grant before 16 new waiting cycles.
REQ-039 Read granted, rst asserted the next cycle -> no rvalid, all outputs 0 during reset, normal grants resume the cycle after rst deasserts.
